rx_flow_ctrl: RTL
=================

# rx_flow_ctrl

Receive-side buffer and hardware flow controller for the UART. It sits between the receiver's frame-complete output and the APB register read path. It captures each completed character, together with its error status, into a FIFO and serves pops from the APB side. It also drives the active-low RTS line with hysteresis, so the receiver controller stops scanning for start bits before the FIFO overruns.

## Interface
Parameters:
- DATA_W, 8, character width in bits.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- RTS_HI, 12, level at or above which RTS is deasserted (rts_no=1); must satisfy RTS_LO < RTS_HI ≤ DEPTH.
- RTS_LO, 4, level at or below which RTS is reasserted.
- RX_TRIG, 1, level at or above which the data interrupt condition is true; 1 ≤ RX_TRIG ≤ DEPTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_en_i  in  1  receiver enable from the control register.
- rx_valid_i  in  1  frame-complete level from the receiver; may be high for one or more cycles per frame.
- rx_data_i  in  DATA_W  received character; stable while rx_valid_i is high.
- parity_err_i  in  1  parity error for the current frame; qualified by rx_valid_i.
- frame_err_i  in  1  stop-bit error for the current frame; qualified by rx_valid_i.
- rd_en_i  in  1  one-cycle pop request from the APB read of the data register.
- clr_err_i  in  1  one-cycle clear of the sticky error flags.
- rd_data_o  out  DATA_W  head entry (first-word fall-through); 0 when empty.
- level_o  out  $clog2(DEPTH)+1  number of stored entries.
- fifo_empty_o  out  1  level_o == 0.
- fifo_full_o  out  1  level_o == DEPTH.
- rts_no  out  1  active-low request-to-send toward the link and the receiver controller.
- overrun_o  out  1  sticky; set when a frame is dropped because the FIFO is full.
- parity_err_o  out  1  sticky parity error.
- frame_err_o  out  1  sticky framing error.
- irq_o  out  1  registered interrupt request.

## Operation
- **Write strobe.** wr = rx_valid_i & ~rx_valid_q, where rx_valid_q is a 1-cycle delayed copy. A multi-cycle valid level yields exactly one write.
- **Write accepted** when wr and (not full, or rd_en_i is popping in the same cycle). On acceptance, rx_data_i goes to the tail and the write pointer increments modulo DEPTH.
- **Write while full** without a simultaneous pop: the data is dropped, overrun_o is set, and the pointers and level are unchanged.
- **Pop accepted** when rd_en_i and not empty; the read pointer increments modulo DEPTH. rd_en_i while empty is ignored and changes no state.
- **Level update.** Simultaneous accepted write and pop: level unchanged. Otherwise level is +1 for a write alone and −1 for a pop alone. Pointers use an extra wrap bit, or level is kept as a counter; either way, full and empty must be unambiguous at wrap-around.
- **Sticky errors.** parity_err_o and frame_err_o are set on wr when the matching input is high, whether or not the data was accepted. clr_err_i clears overrun_o, parity_err_o and frame_err_o. If set and clear occur in the same cycle, set wins.
- **RTS state machine** (states OFF, RUN, HOLD), evaluated on registered level_o:
  - OFF: rts_no=1. Go to RUN when rx_en_i and level_o < RTS_HI; go to HOLD when rx_en_i and level_o ≥ RTS_HI.
  - RUN: rts_no=0. Go to HOLD when level_o ≥ RTS_HI.
  - HOLD: rts_no=1. Go to RUN when level_o ≤ RTS_LO.
  - Any state goes to OFF when rx_en_i=0; this has priority.
- **Receiver disable.** Deasserting rx_en_i does not flush the FIFO. Frames arriving while rx_en_i=0 are still written.
- **Interrupt.** irq_o is registered: (level_o ≥ RX_TRIG) | overrun_o | parity_err_o | frame_err_o.

## Timing
- **Reset values:** pointers, level_o=0, fifo_empty_o=1, fifo_full_o=0, rd_data_o=0, state=OFF, rts_no=1, all sticky flags 0, irq_o=0, rx_valid_q=0.
- **Write latency.** With rx_valid_i rising before edge N (so wr is high in the cycle ending at edge N), the entry is stored and level_o updated at edge N. rd_data_o shows the entry after edge N if the FIFO was empty.
- **Pop.** A pop at edge N makes the next entry visible on rd_data_o after edge N.
- **RTS response.** rts_no changes at the edge after level_o crosses a threshold, i.e. one cycle after the level update. RTS_HI ≤ DEPTH−1 leaves margin for one in-flight frame.
- **irq_o** follows its condition with one cycle of delay.
- **Reset mid-operation** immediately forces all reset values; stored data is discarded.

## Test plan
- **Reset and wrap-around.** Assert reset, then write 0x11..0x20 (16 frames) with no pops → fifo_full_o=1, level_o=16, rts_no=1 from the cycle after level reaches 12. Pop 16 times → data 0x11..0x20 in order, fifo_empty_o=1.
- **Hysteresis.** Fill to 12 → rts_no=1. Pop to level 5 → rts_no stays 1. Pop to level 4 → rts_no=0 one cycle later.
- **Overrun and simultaneous events.** With the FIFO full, write 0xAA → dropped, overrun_o=1. With the FIFO full, write 0xBB and pop in the same cycle → level stays 16 and 0xBB is the last entry out. Pop while empty → no state change.
- **Valid level and errors.** Hold rx_valid_i high for 3 cycles → exactly one write. A frame with parity_err_i=1 → parity_err_o=1 and irq_o=1. clr_err_i coinciding with a new frame_err write → frame_err_o stays 1.
- **Enable and reset.** Drop rx_en_i at level 3 → OFF state, rts_no=1, data retained. Re-enable → RUN, rts_no=0. Assert reset with 5 entries stored → level_o=0 and rts_no=1 immediately.

Source files
------------

// File: rtl/rx_flow_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_flow_ctrl_if : receive buffer data/status/flow-control bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rx_flow_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              rx_en_i;
    logic              rx_valid_i;
    logic [DATA_W-1:0] rx_data_i;
    logic              parity_err_i;
    logic              frame_err_i;
    logic              rd_en_i;
    logic              clr_err_i;
    logic [DATA_W-1:0] rd_data_o;
    logic [LVL_W-1:0]  level_o;
    logic              fifo_empty_o;
    logic              fifo_full_o;
    logic              rts_no;
    logic              overrun_o;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              irq_o;

    modport slave (
        input  rx_en_i, rx_valid_i, rx_data_i, parity_err_i, frame_err_i,
               rd_en_i, clr_err_i,
        output rd_data_o, level_o, fifo_empty_o, fifo_full_o, rts_no,
               overrun_o, parity_err_o, frame_err_o, irq_o
    );

    modport master (
        output rx_en_i, rx_valid_i, rx_data_i, parity_err_i, frame_err_i,
               rd_en_i, clr_err_i,
        input  rd_data_o, level_o, fifo_empty_o, fifo_full_o, rts_no,
               overrun_o, parity_err_o, frame_err_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/rx_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_flow_ctrl : UART receive FIFO with sticky errors and RTS control  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rx_flow_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int RTS_HI  = 12,
    parameter int RTS_LO  = 4,
    parameter int RX_TRIG = 1
) (
    input  logic          clk,
    input  logic          reset,
    rx_flow_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_DEPTH   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_RTS_HI  = LVL_W'(RTS_HI);
    localparam logic [LVL_W-1:0] c_RTS_LO  = LVL_W'(RTS_LO);
    localparam logic [LVL_W-1:0] c_RX_TRIG = LVL_W'(RX_TRIG);
    localparam logic [LVL_W-1:0] c_ONE     = LVL_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rx_valid_q;
    logic              overrun_q, overrun_d;
    logic              parity_q, parity_d;
    logic              frame_q, frame_d;
    logic              irq_q, irq_d;
    state_t            state_q;
    logic              rts_q;

    logic wr_stb, full, empty, wr_ok, rd_ok;

    always_comb begin
        wr_stb = bus.rx_valid_i & ~rx_valid_q;
        full   = (level_q == c_DEPTH);
        empty  = (level_q == '0);
        rd_ok  = bus.rd_en_i & ~empty;
        // A full FIFO still takes a write when the head leaves in the same cycle.
        wr_ok  = wr_stb & (~full | bus.rd_en_i);

        wr_ptr_d = wr_ok ? wr_ptr_q + c_PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + c_PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (wr_ok && !rd_ok) begin
            level_d = level_q + c_ONE;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - c_ONE;
        end

        overrun_d = (wr_stb & ~wr_ok) | (overrun_q & ~bus.clr_err_i);
        parity_d  = (wr_stb & bus.parity_err_i) | (parity_q & ~bus.clr_err_i);
        frame_d   = (wr_stb & bus.frame_err_i) | (frame_q & ~bus.clr_err_i);
        irq_d     = (level_q >= c_RX_TRIG) | overrun_q | parity_q | frame_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.rx_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            parity_q   <= 1'b0;
            frame_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_valid_q <= bus.rx_valid_i;
            overrun_q  <= overrun_d;
            parity_q   <= parity_d;
            frame_q    <= frame_d;
            irq_q      <= irq_d;
        end
    end

    // RTS hysteresis works on the registered level, so it lags the level by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            rts_q   <= 1'b1;
        end else if (!bus.rx_en_i) begin
            state_q <= S_OFF;
            rts_q   <= 1'b1;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (level_q >= c_RTS_HI) begin
                        state_q <= S_HOLD;
                        rts_q   <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        rts_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (level_q >= c_RTS_HI) begin
                        state_q <= S_HOLD;
                        rts_q   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (level_q <= c_RTS_LO) begin
                        state_q <= S_RUN;
                        rts_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    rts_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data_o    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.level_o      = level_q;
    assign bus.fifo_empty_o = empty;
    assign bus.fifo_full_o  = full;
    assign bus.rts_no       = rts_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.parity_err_o = parity_q;
    assign bus.frame_err_o  = frame_q;
    assign bus.irq_o        = irq_q;
endmodule
`default_nettype wire
